// File: rtl/wb_ext_pkg.sv
// Shared types and constants for the external Wishbone arbiter.
package wb_ext_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } arb_state_t;

    localparam int CNT_W = 10;

endpackage

// File: rtl/wb_ext_rr_arb.sv
// Combinational round-robin picker: searches upward from the port after the last owner.
module wb_ext_rr_arb
    import wb_ext_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     last,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [IDX_W-1:0]     gnt_idx
);

    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        cand    = '0;
        found   = 1'b0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = IDX_W'((int'(last) + i) % NUM_PORTS);
            if (!found && req[cand]) begin
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_ext_arbiter.sv
// Round-robin arbiter folding several Wishbone masters onto one downstream port,
// with a stall watchdog that aborts the cycle when the slave never terminates.
module wb_ext_arbiter
    import wb_ext_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_PORTS*32-1:0] m_adr_i,
    input  logic [NUM_PORTS*32-1:0] m_dat_i,
    input  logic [NUM_PORTS*4-1:0]  m_sel_i,
    input  logic [NUM_PORTS*3-1:0]  m_cti_i,
    input  logic [NUM_PORTS*2-1:0]  m_bte_i,
    input  logic [NUM_PORTS-1:0]    m_cyc_i,
    input  logic [NUM_PORTS-1:0]    m_stb_i,
    input  logic [NUM_PORTS-1:0]    m_we_i,
    input  logic [NUM_PORTS-1:0]    m_cab_i,
    output logic [NUM_PORTS-1:0]    m_ack_o,
    output logic [NUM_PORTS-1:0]    m_err_o,
    output logic [NUM_PORTS-1:0]    m_rty_o,
    output logic [NUM_PORTS*32-1:0] m_dat_o,
    output logic [31:0]             s_adr_o,
    output logic [31:0]             s_dat_o,
    output logic [3:0]              s_sel_o,
    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    output logic                    s_we_o,
    output logic                    s_cab_o,
    output logic [2:0]              s_cti_o,
    output logic [1:0]              s_bte_o,
    input  logic                    s_ack_i,
    input  logic                    s_err_i,
    input  logic                    s_rty_i,
    input  logic [31:0]             s_dat_i,
    output logic [NUM_PORTS-1:0]    grant_o
);

    localparam int               IDX_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT - 1);

    arb_state_t           state, state_nxt;
    logic [IDX_W-1:0]     owner, last_owner;
    logic [NUM_PORTS-1:0] grant_q;
    logic [CNT_W-1:0]     stall_cnt;
    logic [NUM_PORTS-1:0] rr_gnt;
    logic [IDX_W-1:0]     rr_idx;
    logic                 own_cyc, own_stb, term, stall, timeout_hit;

    wb_ext_rr_arb #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_rr (
        .req     (m_cyc_i),
        .last    (last_owner),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx)
    );

    assign own_cyc     = m_cyc_i[owner];
    assign own_stb     = m_stb_i[owner];
    assign term        = s_ack_i | s_err_i | s_rty_i;
    assign stall       = (state == BUSY) && own_cyc && own_stb && !term;
    // A termination in the limit cycle clears stall, so ack wins over timeout.
    assign timeout_hit = stall && (stall_cnt == TO_LIMIT);
    assign grant_o     = grant_q;
    assign m_dat_o     = {NUM_PORTS{s_dat_i}};

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (|m_cyc_i) state_nxt = BUSY;
            BUSY:    if (!own_cyc) state_nxt = IDLE;
                     else if (timeout_hit) state_nxt = ABORT;
            ABORT:   if (!own_cyc) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_cti_o = '0;
        s_bte_o = '0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_cab_o = 1'b0;
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        if (state == BUSY) begin
            s_adr_o        = m_adr_i[int'(owner)*32 +: 32];
            s_dat_o        = m_dat_i[int'(owner)*32 +: 32];
            s_sel_o        = m_sel_i[int'(owner)*4 +: 4];
            s_cti_o        = m_cti_i[int'(owner)*3 +: 3];
            s_bte_o        = m_bte_i[int'(owner)*2 +: 2];
            s_cyc_o        = own_cyc;
            s_stb_o        = own_stb;
            s_we_o         = m_we_i[owner];
            s_cab_o        = m_cab_i[owner];
            m_ack_o[owner] = s_ack_i;
            m_err_o[owner] = s_err_i | timeout_hit;
            m_rty_o[owner] = s_rty_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= IDX_W'(NUM_PORTS - 1);
            grant_q    <= '0;
            stall_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && |m_cyc_i) begin
                owner   <= rr_idx;
                grant_q <= rr_gnt;
            end
            if (state != IDLE && state_nxt == IDLE) begin
                last_owner <= owner;
                grant_q    <= '0;
            end
            if (stall && !timeout_hit) stall_cnt <= stall_cnt + CNT_W'(1);
            else                       stall_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_wb_ext_arbiter.sv
// Directed bench for wb_ext_arbiter: arbitration order, bursts, watchdog abort and reset.
module tb_wb_ext_arbiter;

    localparam int NP = 4;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NP*32-1:0] m_adr_i, m_dat_i, m_dat_o;
    logic [NP*4-1:0]  m_sel_i;
    logic [NP*3-1:0]  m_cti_i;
    logic [NP*2-1:0]  m_bte_i;
    logic [NP-1:0]    m_cyc_i, m_stb_i, m_we_i, m_cab_i;
    logic [NP-1:0]    m_ack_o, m_err_o, m_rty_o, grant_o;
    logic [31:0]      s_adr_o, s_dat_o, s_dat_i;
    logic [3:0]       s_sel_o;
    logic [2:0]       s_cti_o;
    logic [1:0]       s_bte_o;
    logic             s_cyc_o, s_stb_o, s_we_o, s_cab_o;
    logic             s_ack_i, s_err_i, s_rty_i;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_ext_arbiter #(.NUM_PORTS(NP), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_cti_i(m_cti_i),
        .m_bte_i(m_bte_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_cab_i(m_cab_i), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
        .m_dat_o(m_dat_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_cab_o(s_cab_o),
        .s_cti_o(s_cti_o), .s_bte_o(s_bte_o), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .s_rty_i(s_rty_i), .s_dat_i(s_dat_i), .grant_o(grant_o)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_cti_i = '0; m_bte_i = '0;
        m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; m_cab_i = '0;
        s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0; s_dat_i = '0;
    endtask

    // Leaves the bench one step after a posedge with reset released and the FSM idle.
    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        m_cyc_i = '1; m_stb_i = '1; s_ack_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (grant_o !== 4'b0000) begin errors++; $display("[TB] FAIL reset_grant got=%b exp=%b", grant_o, 4'b0000); end
        checks++; if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000) begin errors++; $display("[TB] FAIL reset_s_ctrl got=%b exp=%b", {s_cyc_o, s_stb_o, s_we_o}, 3'b000); end
        checks++; if ({m_ack_o, m_err_o, m_rty_o} !== 12'h000) begin errors++; $display("[TB] FAIL reset_term got=%h exp=%h", {m_ack_o, m_err_o, m_rty_o}, 12'h000); end
        clear_inputs();
    endtask

    task automatic test_single();
        do_reset();
        m_cyc_i[2] = 1'b1; m_stb_i[2] = 1'b1; m_we_i[2] = 1'b1; m_sel_i[2*4 +: 4] = 4'hF;
        m_adr_i[2*32 +: 32] = 32'h0000_1000; m_dat_i[2*32 +: 32] = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++; if (grant_o !== 4'b0000) begin errors++; $display("[TB] FAIL single_latency got=%b exp=%b", grant_o, 4'b0000); end
        next_cycle();
        @(negedge clk);
        checks++; if (grant_o !== 4'b0100) begin errors++; $display("[TB] FAIL single_grant got=%b exp=%b", grant_o, 4'b0100); end
        checks++; if (s_adr_o !== 32'h0000_1000) begin errors++; $display("[TB] FAIL single_adr got=%h exp=%h", s_adr_o, 32'h0000_1000); end
        checks++; if (s_dat_o !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL single_wdat got=%h exp=%h", s_dat_o, 32'hDEAD_BEEF); end
        checks++; if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b111) begin errors++; $display("[TB] FAIL single_ctrl got=%b exp=%b", {s_cyc_o, s_stb_o, s_we_o}, 3'b111); end
        next_cycle();
        s_ack_i = 1'b1; s_dat_i = 32'h1234_5678;
        @(negedge clk);
        checks++; if (m_ack_o !== 4'b0100) begin errors++; $display("[TB] FAIL single_ack got=%b exp=%b", m_ack_o, 4'b0100); end
        checks++; if (m_err_o !== 4'b0000) begin errors++; $display("[TB] FAIL single_noerr got=%b exp=%b", m_err_o, 4'b0000); end
        checks++; if (m_dat_o[3*32 +: 32] !== 32'h1234_5678) begin errors++; $display("[TB] FAIL single_bcast got=%h exp=%h", m_dat_o[3*32 +: 32], 32'h1234_5678); end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++; if (s_cyc_o !== 1'b0) begin errors++; $display("[TB] FAIL single_release got=%b exp=%b", s_cyc_o, 1'b0); end
        next_cycle();
        @(negedge clk);
        checks++; if (grant_o !== 4'b0000) begin errors++; $display("[TB] FAIL single_idle got=%b exp=%b", grant_o, 4'b0000); end
    endtask

    task automatic test_fairness();
        logic [3:0] exp;
        do_reset();
        m_cyc_i = '1; m_stb_i = '1;
        for (int k = 0; k < 5; k++) begin
            exp = 4'b0001 << (k % 4);
            next_cycle();
            s_ack_i = 1'b1;
            @(negedge clk);
            checks++; if (grant_o !== exp) begin errors++; $display("[TB] FAIL fair_grant%0d got=%b exp=%b", k, grant_o, exp); end
            checks++; if (m_ack_o !== exp) begin errors++; $display("[TB] FAIL fair_ack%0d got=%b exp=%b", k, m_ack_o, exp); end
            next_cycle();
            s_ack_i = 1'b0; m_cyc_i[k % 4] = 1'b0; m_stb_i[k % 4] = 1'b0;
            next_cycle();
            m_cyc_i[k % 4] = 1'b1; m_stb_i[k % 4] = 1'b1;
            @(negedge clk);
            checks++; if ({grant_o, s_cyc_o} !== 5'b0) begin errors++; $display("[TB] FAIL fair_idle%0d got=%b exp=%b", k, {grant_o, s_cyc_o}, 5'b0); end
        end
        clear_inputs();
    endtask

    task automatic test_burst();
        logic [2:0] cti;
        do_reset();
        m_cyc_i[1] = 1'b1; m_stb_i[1] = 1'b1; m_cti_i[1*3 +: 3] = 3'b010;
        m_adr_i[1*32 +: 32] = 32'h0000_2000;
        next_cycle();
        for (int b = 0; b < 4; b++) begin
            if (b > 0) next_cycle();
            cti = (b == 3) ? 3'b111 : 3'b010;
            m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1;
            m_cti_i[1*3 +: 3] = cti;
            m_adr_i[1*32 +: 32] = 32'h0000_2000 + 32'(b * 4);
            s_ack_i = 1'b1;
            @(negedge clk);
            checks++; if (m_ack_o !== 4'b0010) begin errors++; $display("[TB] FAIL burst_ack%0d got=%b exp=%b", b, m_ack_o, 4'b0010); end
            checks++; if (s_cti_o !== cti) begin errors++; $display("[TB] FAIL burst_cti%0d got=%b exp=%b", b, s_cti_o, cti); end
            checks++; if (s_adr_o !== 32'h0000_2000 + 32'(b * 4)) begin errors++; $display("[TB] FAIL burst_adr%0d got=%h exp=%h", b, s_adr_o, 32'h0000_2000 + 32'(b * 4)); end
        end
        next_cycle();
        s_ack_i = 1'b0; m_cyc_i[1] = 1'b0; m_stb_i[1] = 1'b0;
        next_cycle();
        @(negedge clk);
        checks++; if (grant_o !== 4'b0000) begin errors++; $display("[TB] FAIL burst_gap got=%b exp=%b", grant_o, 4'b0000); end
        next_cycle();
        @(negedge clk);
        checks++; if (grant_o !== 4'b0001) begin errors++; $display("[TB] FAIL burst_next got=%b exp=%b", grant_o, 4'b0001); end
        clear_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1;
        for (int k = 1; k <= TO; k++) begin
            next_cycle();
            @(negedge clk);
            if (k < TO) begin
                checks++; if ({m_err_o, s_cyc_o} !== 5'b00001) begin errors++; $display("[TB] FAIL to_stall%0d got=%b exp=%b", k, {m_err_o, s_cyc_o}, 5'b00001); end
            end else begin
                checks++; if (m_err_o !== 4'b0001) begin errors++; $display("[TB] FAIL to_err got=%b exp=%b", m_err_o, 4'b0001); end
            end
        end
        next_cycle();
        s_ack_i = 1'b1;
        @(negedge clk);
        checks++; if ({s_cyc_o, s_stb_o} !== 2'b00) begin errors++; $display("[TB] FAIL to_abort_cyc got=%b exp=%b", {s_cyc_o, s_stb_o}, 2'b00); end
        checks++; if ({m_ack_o, m_err_o} !== 8'h00) begin errors++; $display("[TB] FAIL to_late_ack got=%h exp=%h", {m_ack_o, m_err_o}, 8'h00); end
        checks++; if (grant_o !== 4'b0001) begin errors++; $display("[TB] FAIL to_abort_grant got=%b exp=%b", grant_o, 4'b0001); end
        next_cycle();
        s_ack_i = 1'b0;
        @(negedge clk);
        checks++; if (s_cyc_o !== 1'b0) begin errors++; $display("[TB] FAIL to_abort_hold got=%b exp=%b", s_cyc_o, 1'b0); end
        next_cycle();
        m_cyc_i[0] = 1'b0; m_stb_i[0] = 1'b0;
        next_cycle();
        @(negedge clk);
        checks++; if (grant_o !== 4'b0000) begin errors++; $display("[TB] FAIL to_idle got=%b exp=%b", grant_o, 4'b0000); end
    endtask

    task automatic test_ack_at_limit();
        do_reset();
        m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1;
        repeat (TO - 1) next_cycle();
        next_cycle();
        s_ack_i = 1'b1;
        @(negedge clk);
        checks++; if (m_ack_o !== 4'b0001) begin errors++; $display("[TB] FAIL limit_ack got=%b exp=%b", m_ack_o, 4'b0001); end
        checks++; if (m_err_o !== 4'b0000) begin errors++; $display("[TB] FAIL limit_noerr got=%b exp=%b", m_err_o, 4'b0000); end
        next_cycle();
        s_ack_i = 1'b0;
        @(negedge clk);
        checks++; if (s_cyc_o !== 1'b1) begin errors++; $display("[TB] FAIL limit_busy got=%b exp=%b", s_cyc_o, 1'b1); end
        for (int j = 2; j < TO; j++) begin
            next_cycle();
            @(negedge clk);
            checks++; if (m_err_o !== 4'b0000) begin errors++; $display("[TB] FAIL limit_cleared%0d got=%b exp=%b", j, m_err_o, 4'b0000); end
        end
        clear_inputs();
    endtask

    task automatic test_mid_burst_reset();
        do_reset();
        m_cyc_i[2] = 1'b1; m_stb_i[2] = 1'b1; m_cti_i[2*3 +: 3] = 3'b010;
        next_cycle();
        s_ack_i = 1'b1;
        @(negedge clk);
        checks++; if (m_ack_o !== 4'b0100) begin errors++; $display("[TB] FAIL rst_beat got=%b exp=%b", m_ack_o, 4'b0100); end
        next_cycle();
        checks++; if (s_cyc_o !== 1'b1) begin errors++; $display("[TB] FAIL rst_active got=%b exp=%b", s_cyc_o, 1'b1); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if ({s_cyc_o, s_stb_o, grant_o} !== 6'b0) begin errors++; $display("[TB] FAIL rst_drop got=%b exp=%b", {s_cyc_o, s_stb_o, grant_o}, 6'b0); end
        checks++; if ({m_ack_o, m_err_o, m_rty_o} !== 12'h000) begin errors++; $display("[TB] FAIL rst_noterm got=%h exp=%h", {m_ack_o, m_err_o, m_rty_o}, 12'h000); end
        s_ack_i = 1'b0;
        m_cyc_i = 4'b0101; m_stb_i = 4'b0101;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        checks++; if (grant_o !== 4'b0001) begin errors++; $display("[TB] FAIL rst_first got=%b exp=%b", grant_o, 4'b0001); end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single();
        test_fairness();
        test_burst();
        test_timeout();
        test_ack_at_limit();
        test_mid_burst_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_ext_arbiter.md
WB_EXT_ARBITER -- requirements
Module: wb_ext_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4: number of upstream Wishbone masters (the wb_ext_* ports of noc_top, one per tile).
REQ-002 SHALL have parameter TIMEOUT, default 255: slave-stall cycles before abort, range 1..1023.
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have ports m_adr_i, m_dat_i, input, NUM_PORTS*32 each: per-master address and write data, with port p at bits [p*32+31:p*32].
REQ-006 SHALL have ports m_sel_i, m_cti_i, m_bte_i, input, NUM_PORTS*4, NUM_PORTS*3 and NUM_PORTS*2: per-master byte select, cycle type and burst type.
REQ-007 SHALL have ports m_cyc_i, m_stb_i, m_we_i, m_cab_i, input, NUM_PORTS each: per-master bus controls.
REQ-008 SHALL have ports m_ack_o, m_err_o, m_rty_o, output, NUM_PORTS each: per-master terminations.
REQ-009 SHALL have port m_dat_o, output, NUM_PORTS*32: per-master read data.
REQ-010 SHALL have ports s_adr_o, s_dat_o, s_sel_o, s_cyc_o, s_stb_o, s_we_o, s_cab_o, s_cti_o, s_bte_o, output: single downstream master port, with widths matching one upstream port.
REQ-011 SHALL have ports s_ack_i, s_err_i, s_rty_i, input, 1 each, and s_dat_i, input, 32: downstream slave response.
REQ-012 SHALL have port grant_o, output, NUM_PORTS: one-hot current owner, for debug visibility.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY and ABORT.
REQ-014 In IDLE, with any m_cyc_i high, SHALL register a round-robin grant starting at (last_owner+1) mod NUM_PORTS and enter BUSY next cycle; grant latency is 1 cycle.
REQ-015 In BUSY, s_* outputs SHALL be combinationally muxed from the granted master; non-granted masters see ack/err/rty=0 and s_cyc_o/s_stb_o reflect only the owner.
REQ-016 s_ack_i/s_err_i/s_rty_i SHALL route combinationally to the owner only; s_dat_i SHALL broadcast on all m_dat_o slices.
REQ-017 Grant SHALL be held while the owner's m_cyc_i is high, covering bursts (cti 3'b010) and back-to-back single transfers; owner cyc low SHALL move BUSY->IDLE and update last_owner.
REQ-018 An IDLE cycle of at least 1 clock SHALL separate successive owners, during which s_cyc_o=0.
REQ-019 A 10-bit stall counter SHALL increment each BUSY cycle with s_stb_o high and no s_ack_i/s_err_i/s_rty_i; any termination or stb low SHALL clear it.
REQ-020 When the counter equals TIMEOUT, the block SHALL pulse m_err_o[owner] for exactly 1 cycle, force s_cyc_o/s_stb_o to 0 and enter ABORT.
REQ-021 ABORT SHALL keep s_cyc_o=0 until the owner's m_cyc_i is low, then go to IDLE; a late s_ack_i arriving in ABORT SHALL be dropped.
REQ-022 A simultaneous timeout and s_ack_i SHALL resolve as ack: no error, counter cleared.
REQ-023 Masters dropping cyc while not granted SHALL lose their pending request; the block keeps no request memory.

Reset
REQ-024 While rst_n is low, the FSM SHALL be IDLE, last_owner=NUM_PORTS-1 (so port 0 wins first), counter=0, grant_o=0, all s_* controls 0 and all m_ack_o/m_err_o/m_rty_o 0.
REQ-025 Reset asserted mid-transfer SHALL drop s_cyc_o in the same cycle (asynchronously); no termination is generated toward the masters.

Structure
REQ-026 State encoding (arb_state_t) and the counter width constant SHALL live in a shared package wb_ext_pkg.
REQ-027 Round-robin selection SHALL be a sub-module wb_ext_rr_arb: combinational request vector plus last owner in, one-hot grant out.

Verification
REQ-028 Bench SHALL cover a single request: m_cyc/stb[2]=1, write 0x1000 data 0xDEADBEEF -> grant_o=4'b0100 after 1 cycle and s_adr_o=0x1000; slave ack -> m_ack_o[2] only.
REQ-029 Bench SHALL cover fairness: all 4 masters request continuously from reset with 1-transfer cycles -> grant order 0,1,2,3,0 with one IDLE cycle between grants.
REQ-030 Bench SHALL cover a burst: master 1 issues a 4-beat incrementing burst while master 0 requests -> master 1 keeps the grant for 4 acks, then master 0 is granted.
REQ-031 Bench SHALL cover a timeout: TIMEOUT=8, slave never acks -> m_err_o[owner] pulses on stall cycle 8, s_cyc_o=0, ABORT holds until owner cyc low, a late ack is ignored.
REQ-032 Bench SHALL cover ack at the limit: ack arrives exactly on stall cycle TIMEOUT -> m_ack_o pulses, m_err_o stays 0.
REQ-033 Bench SHALL cover mid-burst reset: rst_n low during a burst -> all outputs 0 immediately; after release, port 0 is granted first.
